// File: rtl/eq_pkg.sv
// eq_pkg: shared equaliser types and sizes for the sample queue and FIR bands
package eq_pkg;
  localparam int SMPL_W = 16;
  localparam int EQ_TAPS = 1021;
  localparam int CQ_DEPTH = 1024;
  typedef enum logic [1:0] {FILL, IDLE, PRIME, READ} cq_state_t;
endpackage

// File: rtl/smpl_circ_queue_if.sv
// smpl_circ_queue_if: sample-in / burst-out bundle, overrun present under SMPL_CQ_OVERRUN_EN
interface smpl_circ_queue_if #(parameter int SMPL_W = eq_pkg::SMPL_W);
  logic wrt_smpl;
  logic [SMPL_W-1:0] lft_smpl, rght_smpl, lft_out, rght_out;
  logic sequencing, full;
`ifdef SMPL_CQ_OVERRUN_EN
  logic overrun;
`endif
  modport master(
    output wrt_smpl, lft_smpl, rght_smpl,
    input lft_out, rght_out, sequencing, full
`ifdef SMPL_CQ_OVERRUN_EN
    , overrun
`endif
  );
  modport slave(
    input wrt_smpl, lft_smpl, rght_smpl,
    output lft_out, rght_out, sequencing, full
`ifdef SMPL_CQ_OVERRUN_EN
    , overrun
`endif
  );
endinterface

// File: rtl/cq_dpram.sv
// cq_dpram: simple dual-port block RAM with registered, enable-held, resettable read data
module cq_dpram import eq_pkg::*; #(
  parameter int DEPTH = CQ_DEPTH,
  parameter int W = 2 * SMPL_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk) rdata <= rst ? '0 : re ? mem[raddr] : rdata;
endmodule

// File: rtl/smpl_circ_queue.sv
// smpl_circ_queue: stereo circular buffer bursting the latest READ_LEN pairs per sample; SMPL_CQ_OVERRUN_EN adds overrun
module smpl_circ_queue import eq_pkg::*; #(
  parameter int DEPTH = CQ_DEPTH,
  parameter int READ_LEN = EQ_TAPS,
  parameter int SMPL_W = eq_pkg::SMPL_W
) (
  input logic clk,
  input logic rst,
  smpl_circ_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(READ_LEN + 1);
  cq_state_t state, state_nxt;
  logic [AW-1:0] new_ptr, rd_ptr, last_ptr;
  logic [CW-1:0] fill_cnt, fill_nxt, burst_cnt;
  logic pending, last_rd, start, busy, re;
  cq_dpram #(.DEPTH(DEPTH), .W(2 * SMPL_W)) u_ram (
    .clk(clk), .rst(rst),
    .we(bus.wrt_smpl), .waddr(new_ptr), .wdata({bus.lft_smpl, bus.rght_smpl}),
    .re(re), .raddr(rd_ptr), .rdata({bus.lft_out, bus.rght_out})
  );
  assign busy = state == PRIME || state == READ;
  assign last_rd = state == READ && burst_cnt == CW'(READ_LEN - 1);
  assign re = state == PRIME || (state == READ && !last_rd);
  assign last_ptr = bus.wrt_smpl ? new_ptr : new_ptr - AW'(1);
  assign bus.sequencing = state == READ;
  always_comb begin
    start = (bus.wrt_smpl && (state == IDLE || (state == FILL && fill_cnt == CW'(READ_LEN - 1))))
            || (last_rd && (pending || bus.wrt_smpl));
    state_nxt = start ? PRIME : state == PRIME ? READ : last_rd ? IDLE : state;
    fill_nxt = (bus.wrt_smpl && fill_cnt != CW'(READ_LEN)) ? fill_cnt + 1'b1 : fill_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      new_ptr <= '0;
      rd_ptr <= '0;
      fill_cnt <= '0;
      burst_cnt <= '0;
      pending <= 1'b0;
      bus.full <= 1'b0;
    end else begin
      state <= state_nxt;
      new_ptr <= new_ptr + AW'(bus.wrt_smpl);
      rd_ptr <= start ? last_ptr - AW'(READ_LEN - 1) : busy ? rd_ptr + 1'b1 : rd_ptr;
      fill_cnt <= fill_nxt;
      burst_cnt <= state == READ ? burst_cnt + 1'b1 : '0;
      pending <= start ? 1'b0 : (bus.wrt_smpl && busy) ? 1'b1 : pending;
      bus.full <= fill_nxt == CW'(READ_LEN);
    end
  end
`ifdef SMPL_CQ_OVERRUN_EN
  always_ff @(posedge clk) bus.overrun <= rst ? 1'b0 : bus.overrun | (bus.wrt_smpl & pending);
`endif
endmodule
